fetch_decode_execute: RTL and testbench

- Front three stages of the team's 4-cycle-per-instruction-free in-order pipeline.
- Contains instruction fetch (PC plus IF/ID register), decode (ID/EX register) and execute (ALU plus EX/MEM output register).
- Reads an external combinational instruction ROM and an external combinational register-file read port.
- Hands {result, rd, valid} to the downstream memory/writeback stages.

---
 rtl/fde_pkg.sv | 41 ++++
 rtl/fde_alu.sv | 25 ++
 rtl/fetch_decode_execute.sv | 108 ++++++++++
 tb/tb_fetch_decode_execute.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/fde_pkg.sv
// Shared definitions for fetch_decode_execute: opcodes, instruction field
// positions and the packed ID/EX stage register.
package fde_pkg;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_OR  = 2'b01;
    localparam logic [1:0] OP_AND = 2'b10;
    localparam logic [1:0] OP_SUB = 2'b11;

    localparam int INSTR_W = 32;
    localparam int REG_W   = 5;

    localparam int OP_HI  = 31;
    localparam int OP_LO  = 30;
    localparam int RD_HI  = 29;
    localparam int RD_LO  = 25;
    localparam int RS1_HI = 24;
    localparam int RS1_LO = 20;
    localparam int RS2_HI = 19;
    localparam int RS2_LO = 15;
    localparam int IMM_HI = 14;
    localparam int IMM_LO = 0;

    typedef struct packed {
        logic [1:0]       op;
        logic [REG_W-1:0] rd;
        logic [REG_W-1:0] rs1;
        logic [REG_W-1:0] rs2;
    } id_ex_t;

    // Splits a raw instruction word into the fields EX needs; imm is dropped.
    function automatic id_ex_t decode_instr(input logic [INSTR_W-1:0] instr);
        id_ex_t f;
        f.op  = instr[OP_HI:OP_LO];
        f.rd  = instr[RD_HI:RD_LO];
        f.rs1 = instr[RS1_HI:RS1_LO];
        f.rs2 = instr[RS2_HI:RS2_LO];
        return f;
    endfunction

endpackage

// File: rtl/fde_alu.sv
// Combinational two-operand ALU for the execute stage; all results wrap
// modulo 2^DATA_W and no flags are produced.
module fde_alu
    import fde_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic [1:0]        op,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic [DATA_W-1:0] result
);

    always_comb begin
        result = '0;
        unique case (op)
            OP_ADD:  result = a + b;
            OP_OR:   result = a | b;
            OP_AND:  result = a & b;
            OP_SUB:  result = a - b;
            default: result = '0;
        endcase
    end

endmodule

// File: rtl/fetch_decode_execute.sv
// Fetch, decode and execute stages of the in-order pipeline. Build with
// FDE_STALL_EN defined to add a stall input that freezes PC, IF/ID and ID/EX.
module fetch_decode_execute
    import fde_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int PC_W   = 5
) (
    input  logic              clk,
    input  logic              rst,
`ifdef FDE_STALL_EN
    input  logic              stall,
`endif
    output logic [PC_W-1:0]   imem_addr,
    input  logic [31:0]       imem_rdata,
    output logic [4:0]        rf_raddr1,
    output logic [4:0]        rf_raddr2,
    input  logic [DATA_W-1:0] rf_rdata1,
    input  logic [DATA_W-1:0] rf_rdata2,
    output logic [DATA_W-1:0] ex_result,
    output logic [4:0]        ex_rd,
    output logic              ex_valid
);

    logic [PC_W-1:0]    pc_q, pc_d;
    logic [31:0]        if_instr_q, if_instr_d;
    logic               if_valid_q, if_valid_d;
    id_ex_t             id_ex_q, id_ex_d;
    logic               id_valid_q, id_valid_d;
    logic [DATA_W-1:0]  ex_result_q, ex_result_d;
    logic [4:0]         ex_rd_q, ex_rd_d;
    logic               ex_valid_q, ex_valid_d;
    logic [DATA_W-1:0]  alu_result;
    logic               advance;
    logic               unused_imm;

`ifdef FDE_STALL_EN
    assign advance = ~stall;
`else
    assign advance = 1'b1;
`endif

    // The immediate field is reserved; it rides through IF/ID but is never decoded.
    assign unused_imm = ^if_instr_q[IMM_HI:IMM_LO];

    fde_alu #(
        .DATA_W (DATA_W)
    ) u_alu (
        .op     (id_ex_q.op),
        .a      (rf_rdata1),
        .b      (rf_rdata2),
        .result (alu_result)
    );

    always_comb begin
        pc_d        = pc_q;
        if_instr_d  = if_instr_q;
        if_valid_d  = if_valid_q;
        id_ex_d     = id_ex_q;
        id_valid_d  = id_valid_q;
        ex_result_d = ex_result_q;
        ex_rd_d     = ex_rd_q;
        ex_valid_d  = 1'b0;
        if (advance) begin
            pc_d        = pc_q + PC_W'(1);
            if_instr_d  = imem_rdata;
            if_valid_d  = 1'b1;
            id_ex_d     = decode_instr(if_instr_q);
            id_valid_d  = if_valid_q;
            ex_result_d = alu_result;
            ex_rd_d     = id_ex_q.rd;
            ex_valid_d  = id_valid_q;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            pc_q        <= '0;
            if_instr_q  <= '0;
            if_valid_q  <= 1'b0;
            id_ex_q     <= '0;
            id_valid_q  <= 1'b0;
            ex_result_q <= '0;
            ex_rd_q     <= '0;
            ex_valid_q  <= 1'b0;
        end else begin
            pc_q        <= pc_d;
            if_instr_q  <= if_instr_d;
            if_valid_q  <= if_valid_d;
            id_ex_q     <= id_ex_d;
            id_valid_q  <= id_valid_d;
            ex_result_q <= ex_result_d;
            ex_rd_q     <= ex_rd_d;
            ex_valid_q  <= ex_valid_d;
        end
    end

    assign imem_addr = pc_q;
    assign rf_raddr1 = id_ex_q.rs1;
    assign rf_raddr2 = id_ex_q.rs2;

    // ex_valid qualifies ex_result/ex_rd for one cycle; there is no ready,
    // so the downstream stage must take every valid beat.
    assign ex_result = ex_result_q;
    assign ex_rd     = ex_rd_q;
    assign ex_valid  = ex_valid_q;

endmodule

// File: tb/tb_fetch_decode_execute.sv
// Directed plus randomized bench for fetch_decode_execute with an
// edge-count reference model of the ROM-to-EX pipeline.
module tb_fetch_decode_execute;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [4:0]  imem_addr;
    logic [31:0] imem_rdata;
    logic [4:0]  rf_raddr1, rf_raddr2;
    logic [31:0] rf_rdata1, rf_rdata2;
    logic [31:0] ex_result;
    logic [4:0]  ex_rd;
    logic        ex_valid;
`ifdef FDE_STALL_EN
    logic        stall = 1'b0;
`endif

    logic [31:0] rom [32];
    logic [31:0] rf  [32];

    int errors = 0;
    int checks = 0;
    int k = 0;

    always #5 clk = ~clk;

    assign imem_rdata = rom[imem_addr];
    assign rf_rdata1  = rf[rf_raddr1];
    assign rf_rdata2  = rf[rf_raddr2];

    fetch_decode_execute #(.DATA_W(32), .PC_W(5)) dut (
        .clk        (clk),
        .rst        (rst),
`ifdef FDE_STALL_EN
        .stall      (stall),
`endif
        .imem_addr  (imem_addr),
        .imem_rdata (imem_rdata),
        .rf_raddr1  (rf_raddr1),
        .rf_raddr2  (rf_raddr2),
        .rf_rdata1  (rf_rdata1),
        .rf_rdata2  (rf_rdata2),
        .ex_result  (ex_result),
        .ex_rd      (ex_rd),
        .ex_valid   (ex_valid)
    );

    function automatic logic [31:0] mk(input logic [1:0] op, input logic [4:0] rd,
                                       input logic [4:0] rs1, input logic [4:0] rs2);
        return {op, rd, rs1, rs2, 15'h0};
    endfunction

    function automatic logic [31:0] ref_alu(input logic [1:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
        case (op)
            2'd0:    return a + b;
            2'd1:    return a | b;
            2'd2:    return a & b;
            default: return a - b;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic rand_rf(input int lo);
        for (int i = lo; i < 32; i++) rf[i] = $urandom;
    endtask

    // Hold reset for n edges, checking cleared outputs after each.
    task automatic do_reset(input int n);
        rst = 1'b0;
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            chk("rst_imem_addr", 32'(imem_addr), 32'd0);
            chk("rst_ex_valid",  32'(ex_valid),  32'd0);
            chk("rst_ex_result", ex_result,      32'd0);
            chk("rst_ex_rd",     32'(ex_rd),     32'd0);
        end
        rst = 1'b1;
        k = 0;
    endtask

    // One edge out of reset: after edge kn, EX holds ROM[kn-3] (or a zeroed
    // bubble before that), read against the register file as it is now.
    task automatic step_chk();
        int          kn;
        logic [31:0] ins;
        logic [31:0] er;
        logic        ev;
        kn = k + 1;
        if (kn >= 3) begin
            ins = rom[(kn - 3) % 32];
            ev  = 1'b1;
        end else begin
            ins = 32'h0;
            ev  = 1'b0;
        end
        er = ref_alu(ins[31:30], rf[ins[24:20]], rf[ins[19:15]]);
        @(posedge clk); #1;
        k = kn;
        chk("imem_addr", 32'(imem_addr), 32'(k % 32));
        chk("ex_valid",  32'(ex_valid),  32'(ev));
        chk("ex_rd",     32'(ex_rd),     32'(ins[29:25]));
        chk("ex_result", ex_result,      er);
    endtask

    initial begin
        for (int i = 0; i < 32; i++) rom[i] = $urandom;
        rom[0] = mk(2'b00, 5'd1, 5'd2, 5'd3);
        rom[1] = mk(2'b01, 5'd1, 5'd2, 5'd2);
        rom[2] = mk(2'b11, 5'd3, 5'd1, 5'd2);
        rom[3] = mk(2'b00, 5'd6, 5'd4, 5'd5);
        rom[4] = mk(2'b11, 5'd7, 5'd5, 5'd4);
        rom[5] = mk(2'b10, 5'd8, 5'd4, 5'd5);
        rom[6] = mk(2'b01, 5'd9, 5'd4, 5'd5);
        rand_rf(6);
        rf[0] = 32'd0;
        rf[1] = 32'd20;
        rf[2] = 32'd10;
        rf[3] = 32'd5;
        rf[4] = 32'hFFFF_FFFF;
        rf[5] = 32'd1;

        do_reset(3);

        for (int i = 0; i < 40; i++) begin
            step_chk();
            rand_rf(6);
            if (k == 3) chk("prog_add", ex_result, 32'd15);
            if (k == 4) begin
                chk("prog_or_rd", 32'(ex_rd), 32'd1);
                chk("prog_or",    ex_result,  32'd10);
            end
            if (k == 5) begin
                chk("prog_sub_rd",    32'(ex_rd),    32'd3);
                chk("prog_sub",       ex_result,     32'd10);
                chk("prog_sub_valid", 32'(ex_valid), 32'd1);
            end
            if (k == 6) chk("alu_add_wrap", ex_result, 32'd0);
            if (k == 7) chk("alu_sub_wrap", ex_result, 32'd2);
            if (k == 8) chk("alu_and",      ex_result, 32'd1);
            if (k == 9) chk("alu_or",       ex_result, 32'hFFFF_FFFF);
            if (k == 32) chk("pc_wrap", 32'(imem_addr), 32'd0);
            if (k == 35) begin
                chk("rerun_rd",     32'(ex_rd), 32'd1);
                chk("rerun_result", ex_result,  32'd15);
            end
        end

        chk("midstream_valid_before", 32'(ex_valid), 32'd1);
        do_reset(1);
        for (int i = 0; i < 12; i++) begin
            step_chk();
            if (k == 2) chk("post_rst_bubble", 32'(ex_valid), 32'd0);
            if (k == 3) begin
                chk("post_rst_first_valid", 32'(ex_valid), 32'd1);
                chk("post_rst_first_res",   ex_result,     32'd15);
            end
        end

        for (int i = 0; i < 32; i++) rom[i] = $urandom;
        rand_rf(1);
        do_reset(2);
        for (int i = 0; i < 80; i++) begin
            step_chk();
            rand_rf(1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
